// File: rtl/npc_predict_if.sv
// Fetch/EX-side bundle of the next-PC unit: fetch outputs, EX resolution inputs, redirect.
// slave = the npc_predict side, master = the pipeline side.
interface npc_predict_if;
  logic        stall;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic [31:0] ex_offset;
  logic [25:0] ex_index;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport slave (
    input  stall, ex_valid, ex_op, ex_pc, ex_rs, ex_rt, ex_offset, ex_index,
           ex_pred_taken, ex_pred_target,
    output if_pc, if_pred_taken, if_pred_target, redirect, redirect_pc
  );

  modport master (
    output stall, ex_valid, ex_op, ex_pc, ex_rs, ex_rt, ex_offset, ex_index,
           ex_pred_taken, ex_pred_target,
    input  if_pc, if_pred_taken, if_pred_target, redirect, redirect_pc
  );
endinterface

// File: rtl/npc_predict.sv
// Next-PC unit: PC register, BTB with 2-bit counters, EX branch/jump resolution with delay slot.
// The BTB is only built when NPC_BTB_EN is defined; otherwise fetch is static not-taken.
module npc_predict #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
  parameter int unsigned BTB_ENTRIES  = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  npc_predict_if.slave     bus,
  output logic [CNT_W-1:0] mispredict_cnt
);

  typedef enum logic [3:0] {
    OpNone = 4'd0,
    OpBeq  = 4'd1,
    OpBne  = 4'd2,
    OpBlez = 4'd3,
    OpBltz = 4'd4,
    OpBgez = 4'd5,
    OpBgtz = 4'd6,
    OpJ    = 4'd7,
    OpJr   = 4'd8
  } op_e;

  logic             op_valid;
  logic             taken;
  logic             rs_zero;
  logic [31:0]      target;
  logic [31:0]      seq_next;
  logic [31:0]      actual_next;
  logic [31:0]      pred_next;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             pred_taken;
  logic [31:0]      pred_target;

  assign rs_zero  = (bus.ex_rs == 32'd0);
  assign seq_next = bus.ex_pc + 32'd8;

  always_comb begin
    op_valid = 1'b1;
    taken    = 1'b0;
    target   = bus.ex_pc + 32'd4 + bus.ex_offset;
    case (bus.ex_op)
      OpBeq:  taken = (bus.ex_rs == bus.ex_rt);
      OpBne:  taken = (bus.ex_rs != bus.ex_rt);
      OpBlez: taken = bus.ex_rs[31] | rs_zero;
      OpBltz: taken = bus.ex_rs[31];
      OpBgez: taken = ~bus.ex_rs[31];
      OpBgtz: taken = ~bus.ex_rs[31] & ~rs_zero;
      OpJ: begin
        taken  = 1'b1;
        target = {bus.ex_pc[31:28], bus.ex_index, 2'b00};
      end
      OpJr: begin
        taken  = 1'b1;
        target = bus.ex_rs;
      end
      default: op_valid = 1'b0;
    endcase
  end

  assign actual_next     = taken ? target : seq_next;
  assign pred_next       = bus.ex_pred_taken ? bus.ex_pred_target : seq_next;
  assign bus.redirect    = bus.ex_valid & op_valid & (actual_next != pred_next);
  assign bus.redirect_pc = actual_next;

`ifdef NPC_BTB_EN
  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [31:0]            tgt_q [BTB_ENTRIES];
  logic [1:0]             ctr_q [BTB_ENTRIES];
  logic [IDX_W-1:0]       rd_idx, wr_idx;
  logic [TAG_W-1:0]       rd_tag, wr_tag;
  logic [29:0]            wr_word;
  logic                   wr_hit;
  logic                   upd;

  // Entries are keyed by the delay-slot word address (ex_pc + 4).
  assign {rd_tag, rd_idx} = pc_q[31:2];
  assign wr_word          = bus.ex_pc[31:2] + 30'd1;
  assign {wr_tag, wr_idx} = wr_word;
  assign wr_hit           = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign upd              = bus.ex_valid & op_valid;

  assign pred_taken  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && ctr_q[rd_idx][1];
  assign pred_target = tgt_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else if (upd) begin
      if (wr_hit) begin
        if (taken) begin
          if (ctr_q[wr_idx] != 2'b11) ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'd1;
          tgt_q[wr_idx] <= actual_next;
        end else if (ctr_q[wr_idx] != 2'b00) begin
          ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'd1;
        end
      end else if (taken) begin
        valid_q[wr_idx] <= 1'b1;
        tag_q[wr_idx]   <= wr_tag;
        tgt_q[wr_idx]   <= actual_next;
        ctr_q[wr_idx]   <= 2'b10;
      end
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign pred_target = 32'd0;
`endif

  // Redirect beats stall: the delay slot has already been fetched, so the wrong path must go.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (bus.redirect) begin
      pc_d = actual_next;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (bus.redirect) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.if_pc          = pc_q;
  assign bus.if_pred_taken  = pred_taken;
  assign bus.if_pred_target = pred_target;
  assign mispredict_cnt     = cnt_q;

endmodule

// File: tb/tb_npc_predict.sv
// Directed bench for npc_predict; prediction expectations follow NPC_BTB_EN.
module tb_npc_predict;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mispredict_cnt;
  logic [15:0] exp_cnt;
  int          errors = 0;
  int          checks = 0;

`ifdef NPC_BTB_EN
  localparam bit BtbOn = 1'b1;
`else
  localparam bit BtbOn = 1'b0;
`endif

  npc_predict_if bus ();

  npc_predict #(
    .RESET_VECTOR(32'h0000_3000),
    .BTB_ENTRIES (16),
    .CNT_W       (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle_ex();
    bus.ex_valid       = 1'b0;
    bus.ex_op          = 4'd0;
    bus.ex_pc          = 32'd0;
    bus.ex_rs          = 32'd0;
    bus.ex_rt          = 32'd0;
    bus.ex_offset      = 32'd0;
    bus.ex_index       = 26'd0;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = 32'd0;
  endtask

  task automatic set_ex(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] off, input logic [25:0] idx,
                        input logic pt, input logic [31:0] ptgt);
    bus.ex_valid       = 1'b1;
    bus.ex_op          = op;
    bus.ex_pc          = pc;
    bus.ex_rs          = rs;
    bus.ex_rt          = rt;
    bus.ex_offset      = off;
    bus.ex_index       = idx;
    bus.ex_pred_taken  = pt;
    bus.ex_pred_target = ptgt;
  endtask

  // JR from 0x5000 with no prediction: forces if_pc to addr after one edge.
  task automatic jump_to(input logic [31:0] addr);
    @(negedge clk);
    set_ex(4'd8, 32'h0000_5000, addr, 32'd0, 32'd0, 26'd0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    idle_ex();
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    idle_ex();
    bus.stall = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.if_pc !== 32'h0000_3000) begin
      errors++; $display("FAIL reset_pc: got %h want %h", bus.if_pc, 32'h0000_3000);
    end
    checks++;
    if (mispredict_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", mispredict_cnt);
    end
    checks++;
    if (bus.if_pred_taken !== 1'b0 || bus.if_pred_target !== 32'd0) begin
      errors++; $display("FAIL reset_pred: got %b/%h want 0/0", bus.if_pred_taken,
                         bus.if_pred_target);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 16'd0;
  endtask

  task automatic test_sequential();
    logic [31:0] want;
    #1;
    checks++;
    if (bus.if_pc !== 32'h0000_3000) begin
      errors++; $display("FAIL seq_pc0: got %h want %h", bus.if_pc, 32'h0000_3000);
    end
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      want = 32'h0000_3000 + 32'(4 * i);
      checks++;
      if (bus.if_pc !== want) begin
        errors++; $display("FAIL seq_pc%0d: got %h want %h", i, bus.if_pc, want);
      end
    end
    @(negedge clk);
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.if_pc !== 32'h0000_300C) begin
        errors++; $display("FAIL stall_hold%0d: got %h want %h", i, bus.if_pc, 32'h0000_300C);
      end
    end
    @(negedge clk);
    bus.stall = 1'b0;
  endtask

  task automatic test_cold_beq();
    @(negedge clk);
    set_ex(4'd1, 32'h0000_3010, 32'd5, 32'd5, 32'h20, 26'd0, 1'b0, 32'd0);
    #1;
    checks++;
    if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0000_3034) begin
      errors++; $display("FAIL cold_beq_redirect: got %b/%h want 1/%h", bus.redirect,
                         bus.redirect_pc, 32'h0000_3034);
    end
    @(posedge clk);
    #1;
    idle_ex();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (bus.if_pc !== 32'h0000_3034 || mispredict_cnt !== exp_cnt) begin
      errors++; $display("FAIL cold_beq_pc_cnt: got %h/%0d want %h/%0d", bus.if_pc,
                         mispredict_cnt, 32'h0000_3034, exp_cnt);
    end
  endtask

  task automatic test_warm_beq();
    jump_to(32'h0000_3014);
    checks++;
    if (bus.if_pred_taken !== BtbOn ||
        bus.if_pred_target !== (BtbOn ? 32'h0000_3034 : 32'd0)) begin
      errors++; $display("FAIL warm_lookup: got %b/%h want %b", bus.if_pred_taken,
                         bus.if_pred_target, BtbOn);
    end
    @(negedge clk);
    set_ex(4'd1, 32'h0000_3010, 32'd5, 32'd5, 32'h20, 26'd0, 1'b1, 32'h0000_3034);
    #1;
    checks++;
    if (bus.redirect !== 1'b0) begin
      errors++; $display("FAIL warm_beq_redirect: got %b want 0", bus.redirect);
    end
    @(posedge clk);
    #1;
    idle_ex();
    checks++;
    if (mispredict_cnt !== exp_cnt) begin
      errors++; $display("FAIL warm_beq_cnt: got %0d want %0d", mispredict_cnt, exp_cnt);
    end
  endtask

  task automatic test_counter_decay();
    jump_to(32'h0000_3014);
    @(negedge clk);
    set_ex(4'd2, 32'h0000_3010, 32'd7, 32'd7, 32'h20, 26'd0, 1'b1, 32'h0000_3034);
    #1;
    checks++;
    if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0000_3018) begin
      errors++; $display("FAIL decay1_redirect: got %b/%h want 1/%h", bus.redirect,
                         bus.redirect_pc, 32'h0000_3018);
    end
    // Same-index update in flight: lookup still reflects the pre-edge counter.
    checks++;
    if (bus.if_pred_taken !== BtbOn) begin
      errors++; $display("FAIL decay1_old_entry: got %b want %b", bus.if_pred_taken, BtbOn);
    end
    @(posedge clk);
    #1;
    idle_ex();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (bus.if_pc !== 32'h0000_3018) begin
      errors++; $display("FAIL decay1_pc: got %h want %h", bus.if_pc, 32'h0000_3018);
    end
    jump_to(32'h0000_3014);
    checks++;
    if (bus.if_pred_taken !== BtbOn) begin
      errors++; $display("FAIL decay_ctr10_pred: got %b want %b", bus.if_pred_taken, BtbOn);
    end
    @(negedge clk);
    set_ex(4'd2, 32'h0000_3010, 32'd7, 32'd7, 32'h20, 26'd0, 1'b1, 32'h0000_3034);
    @(posedge clk);
    #1;
    idle_ex();
    exp_cnt = exp_cnt + 16'd1;
    jump_to(32'h0000_3014);
    checks++;
    if (bus.if_pred_taken !== 1'b0) begin
      errors++; $display("FAIL decay_ctr01_pred: got %b want 0", bus.if_pred_taken);
    end
    checks++;
    if (mispredict_cnt !== exp_cnt) begin
      errors++; $display("FAIL decay_cnt: got %0d want %0d", mispredict_cnt, exp_cnt);
    end
  endtask

  task automatic test_jumps_stall();
    @(negedge clk);
    bus.stall = 1'b1;
    set_ex(4'd8, 32'h0000_3020, 32'h0040_0000, 32'd0, 32'd0, 26'd0, 1'b0, 32'd0);
    #1;
    checks++;
    if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0040_0000) begin
      errors++; $display("FAIL jr_redirect: got %b/%h want 1/%h", bus.redirect,
                         bus.redirect_pc, 32'h0040_0000);
    end
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (bus.if_pc !== 32'h0040_0000) begin
      errors++; $display("FAIL jr_stall_pc: got %h want %h", bus.if_pc, 32'h0040_0000);
    end
    @(negedge clk);
    set_ex(4'd7, 32'h8000_0010, 32'd0, 32'd0, 32'd0, 26'h100, 1'b0, 32'd0);
    #1;
    checks++;
    if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h8000_0400) begin
      errors++; $display("FAIL j_redirect: got %b/%h want 1/%h", bus.redirect,
                         bus.redirect_pc, 32'h8000_0400);
    end
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    set_ex(4'd7, 32'h8000_0010, 32'd0, 32'd0, 32'd0, 26'h100, 1'b1, 32'h8000_0400);
    #1;
    checks++;
    if (bus.redirect !== 1'b0) begin
      errors++; $display("FAIL j_predicted: got %b want 0", bus.redirect);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.if_pc !== 32'h8000_0400) begin
      errors++; $display("FAIL j_stall_hold: got %h want %h", bus.if_pc, 32'h8000_0400);
    end
    idle_ex();
    @(negedge clk);
    bus.stall = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] off;
    logic        redir;
    logic [31:0] rpc;
  } vec_t;

  task automatic test_cond_branches();
    vec_t vecs [15] = '{
      '{1'b1, 4'd3, 32'h0000_0000, 32'd0, 32'h40, 1'b1, 32'h0000_6044},
      '{1'b1, 4'd3, 32'h0000_0001, 32'd0, 32'h40, 1'b0, 32'h0000_6008},
      '{1'b1, 4'd3, 32'hFFFF_FFFF, 32'd0, 32'h40, 1'b1, 32'h0000_6044},
      '{1'b1, 4'd4, 32'hFFFF_FFFF, 32'd0, 32'h40, 1'b1, 32'h0000_6044},
      '{1'b1, 4'd4, 32'h0000_0000, 32'd0, 32'h40, 1'b0, 32'h0000_6008},
      '{1'b1, 4'd5, 32'h0000_0000, 32'd0, 32'h40, 1'b1, 32'h0000_6044},
      '{1'b1, 4'd5, 32'h8000_0000, 32'd0, 32'h40, 1'b0, 32'h0000_6008},
      '{1'b1, 4'd6, 32'h0000_0001, 32'd0, 32'h40, 1'b1, 32'h0000_6044},
      '{1'b1, 4'd6, 32'h0000_0000, 32'd0, 32'h40, 1'b0, 32'h0000_6008},
      '{1'b1, 4'd2, 32'h0000_0001, 32'd2, 32'h40, 1'b1, 32'h0000_6044},
      '{1'b1, 4'd1, 32'h0000_0001, 32'd2, 32'h40, 1'b0, 32'h0000_6008},
      '{1'b1, 4'd1, 32'h0000_0009, 32'd9, 32'hFFFF_FFF0, 1'b1, 32'h0000_5FF4},
      '{1'b1, 4'd9, 32'h0000_0009, 32'd9, 32'h40, 1'b0, 32'h0000_6008},
      '{1'b1, 4'd15, 32'h0000_0009, 32'd9, 32'h40, 1'b0, 32'h0000_6008},
      '{1'b0, 4'd1, 32'h0000_0009, 32'd9, 32'h40, 1'b0, 32'h0000_6044}
    };
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      set_ex(vecs[i].op, 32'h0000_6000, vecs[i].rs, vecs[i].rt, vecs[i].off, 26'd0, 1'b0, 32'd0);
      bus.ex_valid = vecs[i].v;
      #1;
      checks++;
      if (bus.redirect !== vecs[i].redir || bus.redirect_pc !== vecs[i].rpc) begin
        errors++; $display("FAIL cond_vec%0d: got %b/%h want %b/%h", i, bus.redirect,
                           bus.redirect_pc, vecs[i].redir, vecs[i].rpc);
      end
      if (vecs[i].redir) exp_cnt = exp_cnt + 16'd1;
    end
    @(negedge clk);
    idle_ex();
    #1;
    checks++;
    if (mispredict_cnt !== exp_cnt) begin
      errors++; $display("FAIL cond_cnt: got %0d want %0d", mispredict_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_redirect();
    @(negedge clk);
    set_ex(4'd8, 32'h0000_7000, 32'h1234_5678, 32'd0, 32'd0, 26'd0, 1'b0, 32'd0);
    #1;
    checks++;
    if (bus.redirect !== 1'b1) begin
      errors++; $display("FAIL rstmid_redirect: got %b want 1", bus.redirect);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.if_pc !== 32'h0000_3000 || mispredict_cnt !== 16'd0) begin
      errors++; $display("FAIL rstmid_state: got %h/%0d want %h/0", bus.if_pc, mispredict_cnt,
                         32'h0000_3000);
    end
    @(negedge clk);
    idle_ex();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.if_pc !== 32'h0000_3004 || mispredict_cnt !== 16'd0) begin
      errors++; $display("FAIL rstmid_after: got %h/%0d want %h/0", bus.if_pc, mispredict_cnt,
                         32'h0000_3004);
    end
  endtask

  initial begin
    exp_cnt = 16'd0;
    test_reset();
    test_sequential();
    test_cold_beq();
    test_warm_beq();
    test_counter_decay();
    test_jumps_stall();
    test_cond_branches();
    test_reset_mid_redirect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
